pattern_seq_ctrl: RTL and testbench
===================================

# pattern_seq_ctrl

Frame-synchronous controller that sequences the test-pattern mode of the colour-bar/timing generator. Commits host pattern changes only on a vertical-sync start, so the generator never switches mid-frame. Optionally auto-cycles patterns every N frames. Sits between the host/register interface and the generator's 2-bit pattern-mode select, and observes the generator's `vs`/`de` outputs.

## Interface

Parameters:
- `VS_POLORY`, 1'b1: polarity of `i_vs`; 1 = active-high.
- `INIT_MODE`, 2'd2: `o_mode` after reset (colour bar).
- `INIT_DWELL`, 8'd0: dwell register after reset; 0 = auto-cycle disabled.
- `MODE_MAX`, 2'd2: highest mode visited by auto-cycle; mode 3 (external input) is only reachable by host config.
- `TIMEOUT_CYC`, 24'd1_000_000: maximum `S_PEND` wait before a forced commit.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous active-low reset.
- `i_vs` in 1: vertical sync from the generator.
- `i_de` in 1: data enable from the generator.
- `i_cfg_valid` in 1: host config request.
- `i_cfg_mode` in 2: requested mode.
- `i_cfg_dwell` in 8: requested dwell in frames; 0 = hold.
- `o_cfg_ready` out 1: controller can accept a config.
- `o_cfg_done` out 1: one-cycle pulse when the staged config commits.
- `o_timeout` out 1: sticky flag, set on a forced commit; cleared by `i_err_clr`.
- `i_err_clr` in 1: clears `o_timeout` and `o_de_err`.
- `o_mode` out 2: applied pattern mode, drives the generator.
- `o_switch` out 1: one-cycle pulse whenever `o_mode` is written (host commit or auto step).
- `o_frame_cnt` out 16: frame counter.
- `o_de_err` out 1: sticky de-during-vsync flag.

## Operation

Sync conditioning:
- `vs_n` = `i_vs` when `VS_POLORY` = 1, otherwise `~i_vs`.
- `vs_n` is registered into `vs_d1`, then `vs_d2`. Both reset to 1.
- `frame_start` = `vs_d1 & ~vs_d2`.
- Because both registers reset to 1, no spurious `frame_start` occurs if vsync is already active when reset releases.

State machine, states `S_RUN` and `S_PEND`:
- **S_RUN:** `o_cfg_ready` = 1.
  - On `i_cfg_valid & o_cfg_ready`: stage mode and dwell, clear the timeout counter, go to `S_PEND`.
  - If a handshake and `frame_start` occur in the same cycle, the handshake wins. The auto step for that frame is skipped and the dwell count holds.
  - Otherwise, on `frame_start` with dwell ≠ 0:
    - If dwell count == dwell − 1: `o_mode` ← (`o_mode` ≥ `MODE_MAX`) ? 0 : `o_mode` + 1; dwell count ← 0; pulse `o_switch`.
    - Else: dwell count increments.
  - With dwell = 0, `o_mode` holds and the dwell count stays 0.
- **S_PEND:** `o_cfg_ready` = 0; auto stepping is frozen; the timeout counter increments each cycle.
  - On `frame_start`: commit. `o_mode` ← staged mode; dwell ← staged dwell; dwell count ← 0; pulse `o_cfg_done` and `o_switch`; go to `S_RUN`.
  - If the timeout counter reaches `TIMEOUT_CYC` − 1 without a `frame_start`: same commit, and also set `o_timeout`.
  - If `frame_start` and timeout coincide, `frame_start` wins and `o_timeout` is not set.
- A commit whose staged mode equals the current mode still pulses `o_switch`.

Frame counter:
- `o_frame_cnt` increments on every `frame_start` in any state.
- Wraps 16'hFFFF → 0.

Reset:
- Asserting reset in any state, including mid-`S_PEND`, discards the staged config and returns to `S_RUN`.
- Reset values:
  - `o_mode` = `INIT_MODE`; dwell = `INIT_DWELL`.
  - `o_cfg_ready` = 1.
  - `o_cfg_done`, `o_switch`, `o_timeout`, `o_de_err` = 0.
  - `o_frame_cnt` = 0; dwell and timeout counters = 0.

## Timing

- First edge sampling active `i_vs` = edge k. `frame_start` is high between k and k+1. `o_mode`, `o_switch`, `o_cfg_done` and `o_frame_cnt` update at edge k+1.
- Handshake: transfer occurs on the edge where `i_cfg_valid` and `o_cfg_ready` are both high. `o_cfg_ready` is low from the next cycle.
- The host must hold `i_cfg_valid` until transfer. The config is sampled only at the transfer edge.
- `o_cfg_ready` returns to 1 in the cycle after `o_cfg_done`.
- `o_cfg_done` and `o_switch` are single-cycle registered pulses.
- `i_err_clr` has priority over a same-cycle set of `o_timeout` or `o_de_err`.

## Configuration

- Macro `PATSEQ_DE_CHECK_EN`:
  - **Defined:** `o_de_err` is set if `i_de` = 1 in any cycle where `vs_d1` = 1. It stays set until `i_err_clr`.
  - **Undefined:** checker logic is not built and `o_de_err` is tied to 0.

## Test plan

- **Reset release with active vsync:** hold `i_vs` = 1 through reset release → no `o_switch`; `o_frame_cnt` = 0 until the next rising edge of `i_vs`; `o_mode` = 2.
- **Host change:** config mode = 1, dwell = 0, mid-frame → `o_cfg_ready` drops the next cycle; `o_mode` stays 2 until `vs` rises, then `o_mode` = 1 and `o_cfg_done` and `o_switch` pulse at edge k+1.
- **Auto-cycle:** dwell = 3, `MODE_MAX` = 2, start mode 0 over 10 frames → `o_mode` sequence 0,0,0,1,1,1,2,2,2,0; `o_switch` pulses every third frame.
- **Simultaneous handshake and frame start:** dwell = 1, assert handshake in the `frame_start` cycle → no auto step that frame; commit at the following frame start.
- **Timeout:** `TIMEOUT_CYC` = 100, no `vs`, config mode = 3 → after 100 cycles in `S_PEND`, `o_mode` = 3 and `o_timeout` = 1; `i_err_clr` clears `o_timeout`.
- **DE check:** with `PATSEQ_DE_CHECK_EN`, drive `i_de` = 1 during vsync → `o_de_err` = 1 and stays set until `i_err_clr`. Without the macro, `o_de_err` stays 0.

Source files
------------

// File: rtl/pattern_seq_ctrl.sv
// rtl/pattern_seq_ctrl.sv - frame-synchronous test-pattern mode sequencer with optional auto-cycle
// Optional feature macro: PATSEQ_DE_CHECK_EN (builds the de-during-vsync checker)
module pattern_seq_ctrl #(
  parameter logic        VS_POLORY   = 1'b1,
  parameter logic [1:0]  INIT_MODE   = 2'd2,
  parameter logic [7:0]  INIT_DWELL  = 8'd0,
  parameter logic [1:0]  MODE_MAX    = 2'd2,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic        i_cfg_valid,
  input  logic [1:0]  i_cfg_mode,
  input  logic [7:0]  i_cfg_dwell,
  output logic        o_cfg_ready,
  output logic        o_cfg_done,
  output logic        o_timeout,
  input  logic        i_err_clr,
  output logic [1:0]  o_mode,
  output logic        o_switch,
  output logic [15:0] o_frame_cnt,
  output logic        o_de_err
);

  typedef enum logic {S_RUN = 1'b0, S_PEND = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        vs_n;
  logic        vs_d1_q, vs_d2_q;
  logic        frame_start;
  logic        cfg_ready;
  logic        handshake;
  logic        tmo_hit;
  logic        commit;
  logic        auto_step;

  logic [1:0]  mode_q, mode_d;
  logic [7:0]  dwell_q, dwell_d;
  logic [7:0]  dcnt_q, dcnt_d;
  logic [23:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0]  stage_mode_q, stage_mode_d;
  logic [7:0]  stage_dwell_q, stage_dwell_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        timeout_q, timeout_d;
  logic        switch_q, done_q;

  assign vs_n = VS_POLORY ? i_vs : ~i_vs;

  // Two-stage vsync history; both start at 1 so an already-active vsync at reset release is not a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d1_q <= 1'b1;
      vs_d2_q <= 1'b1;
    end else begin
      vs_d1_q <= vs_n;
      vs_d2_q <= vs_d1_q;
    end
  end

  assign frame_start = vs_d1_q & ~vs_d2_q;
  assign handshake   = i_cfg_valid & cfg_ready;
  assign tmo_hit     = (tmo_cnt_q == TIMEOUT_CYC - 24'd1);
  assign commit      = (state_q == S_PEND) & (frame_start | tmo_hit);
  assign auto_step   = (state_q == S_RUN) & ~handshake & frame_start &
                       (dwell_q != 8'd0) & (dcnt_q == dwell_q - 8'd1);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // FSM next state: a transfer stages a config, a commit returns to running
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (handshake) state_d = S_PEND;
      S_PEND:  if (commit)    state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // FSM outputs: ready only while running, held off for the cycle the done pulse is visible
  always_comb begin
    cfg_ready = (state_q == S_RUN) & ~done_q;
  end

  // Datapath next state: staging, auto-cycle stepping, commit and the pending-wait timer
  always_comb begin
    mode_d        = mode_q;
    dwell_d       = dwell_q;
    dcnt_d        = dcnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    stage_mode_d  = stage_mode_q;
    stage_dwell_d = stage_dwell_q;
    if (state_q == S_RUN) begin
      if (handshake) begin
        stage_mode_d  = i_cfg_mode;
        stage_dwell_d = i_cfg_dwell;
        tmo_cnt_d     = 24'd0;
      end else if (frame_start && dwell_q != 8'd0) begin
        if (auto_step) begin
          mode_d = (mode_q >= MODE_MAX) ? 2'd0 : mode_q + 2'd1;
          dcnt_d = 8'd0;
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end
    end else begin
      if (commit) begin
        mode_d  = stage_mode_q;
        dwell_d = stage_dwell_q;
        dcnt_d  = 8'd0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 24'd1;
      end
    end
  end

  // Frame counter advances on every frame start regardless of state, wrapping naturally
  always_comb begin
    frame_cnt_d = frame_start ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  // Sticky timeout: only a forced commit (no frame start that cycle) sets it; clear wins
  always_comb begin
    timeout_d = timeout_q;
    if (i_err_clr) timeout_d = 1'b0;
    else if ((state_q == S_PEND) && tmo_hit && !frame_start) timeout_d = 1'b1;
  end

  // Datapath registers and single-cycle event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q        <= INIT_MODE;
      dwell_q       <= INIT_DWELL;
      dcnt_q        <= 8'd0;
      tmo_cnt_q     <= 24'd0;
      stage_mode_q  <= 2'd0;
      stage_dwell_q <= 8'd0;
      frame_cnt_q   <= 16'd0;
      timeout_q     <= 1'b0;
      switch_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      dwell_q       <= dwell_d;
      dcnt_q        <= dcnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      stage_mode_q  <= stage_mode_d;
      stage_dwell_q <= stage_dwell_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_q     <= timeout_d;
      switch_q      <= commit | auto_step;
      done_q        <= commit;
    end
  end

`ifdef PATSEQ_DE_CHECK_EN
  logic de_err_q;

  // Sticky flag for data enable seen while vsync is active; clear wins over a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 de_err_q <= 1'b0;
    else if (i_err_clr)         de_err_q <= 1'b0;
    else if (i_de && vs_d1_q)   de_err_q <= 1'b1;
  end

  assign o_de_err = de_err_q;
`else
  // Checker not built; i_de is intentionally ignored
  assign o_de_err = i_de & 1'b0;
`endif

  assign o_cfg_ready = cfg_ready;
  assign o_cfg_done  = done_q;
  assign o_timeout   = timeout_q;
  assign o_mode      = mode_q;
  assign o_switch    = switch_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// tb/tb_pattern_seq_ctrl.sv - scoreboard bench for pattern_seq_ctrl
module tb_pattern_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_vs, i_de, i_cfg_valid, i_err_clr;
  logic [1:0]  i_cfg_mode;
  logic [7:0]  i_cfg_dwell;
  logic        o_cfg_ready, o_cfg_done, o_timeout, o_switch, o_de_err;
  logic [1:0]  o_mode;
  logic [15:0] o_frame_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] mode;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

`ifdef PATSEQ_DE_CHECK_EN
  localparam logic DE_EXP = 1'b1;
`else
  localparam logic DE_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  pattern_seq_ctrl #(.TIMEOUT_CYC(24'd100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_vs        (i_vs),
    .i_de        (i_de),
    .i_cfg_valid (i_cfg_valid),
    .i_cfg_mode  (i_cfg_mode),
    .i_cfg_dwell (i_cfg_dwell),
    .o_cfg_ready (o_cfg_ready),
    .o_cfg_done  (o_cfg_done),
    .o_timeout   (o_timeout),
    .i_err_clr   (i_err_clr),
    .o_mode      (o_mode),
    .o_switch    (o_switch),
    .o_frame_cnt (o_frame_cnt),
    .o_de_err    (o_de_err)
  );

  // Monitor: every switch pulse must match the next expected event
  always @(negedge clk) begin
    if (o_switch === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_switch mode=%0d done=%0d", o_mode, o_cfg_done);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_mode !== mon_e.mode || o_cfg_done !== mon_e.done) begin
          bad++;
          $display("FAIL switch_event got mode=%0d done=%0d expected mode=%0d done=%0d",
                   o_mode, o_cfg_done, mon_e.mode, mon_e.done);
        end
      end
    end else if (o_cfg_done === 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_without_switch got done=1 expected switch=1");
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] m, input logic d);
    exp_t e;
    e.mode = m;
    e.done = d;
    exp_q.push_back(e);
  endtask

  task automatic send_cfg(input logic [1:0] m, input logic [7:0] dw);
    i_cfg_valid = 1'b1;
    i_cfg_mode  = m;
    i_cfg_dwell = dw;
    tick(1);
    i_cfg_valid = 1'b0;
  endtask

  task automatic frame_gap();
    i_vs = 1'b0;
    tick(3);
  endtask

  logic [1:0] auto_seq [10];

  initial begin
    auto_seq = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
    rst_n = 1'b0; i_vs = 1'b1; i_de = 1'b0; i_cfg_valid = 1'b0;
    i_cfg_mode = 2'd0; i_cfg_dwell = 8'd0; i_err_clr = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check("reset_mode", o_mode, 2);
    check("reset_frame_cnt", o_frame_cnt, 0);
    check("reset_ready", o_cfg_ready, 1);
    check("reset_switch", o_switch, 0);
    check("reset_timeout", o_timeout, 0);
    check("reset_de_err", o_de_err, 0);
    frame_gap();
    check("no_frame_after_release", o_frame_cnt, 0);

    // Host change mid-frame
    push(2'd1, 1'b1);
    send_cfg(2'd1, 8'd0);
    check("ready_drop", o_cfg_ready, 0);
    tick(3);
    check("mode_hold_pending", o_mode, 2);
    i_vs = 1'b1;
    tick(1);
    check("mode_in_fs_cycle", o_mode, 2);
    tick(1);
    check("host_commit_mode", o_mode, 1);
    check("host_commit_done", o_cfg_done, 1);
    tick(1);
    check("done_single_pulse", o_cfg_done, 0);
    check("ready_back", o_cfg_ready, 1);
    check("frame_cnt_1", o_frame_cnt, 1);
    frame_gap();

    // Auto-cycle, dwell 3 from mode 0
    push(2'd0, 1'b1);
    send_cfg(2'd0, 8'd3);
    tick(2);
    for (int i = 0; i < 10; i++) begin
      if (i == 3 || i == 6 || i == 9) push(auto_seq[i], 1'b0);
      i_vs = 1'b1;
      tick(2);
      check($sformatf("auto_mode_f%0d", i), o_mode, auto_seq[i]);
      frame_gap();
    end
    check("frame_cnt_11", o_frame_cnt, 11);

    // Handshake coinciding with frame start, dwell 1
    push(2'd1, 1'b1);
    send_cfg(2'd1, 8'd1);
    i_vs = 1'b1;
    tick(2);
    check("dwell1_commit_mode", o_mode, 1);
    frame_gap();
    i_vs = 1'b1;
    tick(1);
    i_cfg_valid = 1'b1; i_cfg_mode = 2'd0; i_cfg_dwell = 8'd0;
    tick(1);
    i_cfg_valid = 1'b0;
    check("no_auto_step_on_handshake", o_mode, 1);
    check("ready_low_after_sim", o_cfg_ready, 0);
    check("frame_cnt_13", o_frame_cnt, 13);
    frame_gap();
    push(2'd0, 1'b1);
    i_vs = 1'b1;
    tick(2);
    check("sim_commit_mode", o_mode, 0);
    frame_gap();

    // Timeout with no vsync
    push(2'd3, 1'b1);
    send_cfg(2'd3, 8'd0);
    tick(98);
    check("tmo_not_yet_mode", o_mode, 0);
    check("tmo_not_yet_flag", o_timeout, 0);
    tick(1);
    check("tmo_edge99_mode", o_mode, 0);
    tick(1);
    check("tmo_commit_mode", o_mode, 3);
    check("tmo_flag_set", o_timeout, 1);
    tick(2);
    check("tmo_flag_sticky", o_timeout, 1);
    i_err_clr = 1'b1;
    tick(1);
    i_err_clr = 1'b0;
    check("tmo_flag_cleared", o_timeout, 0);

    // DE during vsync
    i_vs = 1'b1; i_de = 1'b1;
    tick(2);
    i_de = 1'b0;
    check("de_err_set", o_de_err, DE_EXP);
    frame_gap();
    check("de_err_sticky", o_de_err, DE_EXP);
    check("mode_hold_dwell0", o_mode, 3);
    i_err_clr = 1'b1;
    tick(1);
    i_err_clr = 1'b0;
    check("de_err_cleared", o_de_err, 0);

    // Reset while pending discards the staged config
    send_cfg(2'd1, 8'd0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("rst_pend_mode", o_mode, 2);
    check("rst_pend_ready", o_cfg_ready, 1);
    check("rst_pend_frame_cnt", o_frame_cnt, 0);
    i_vs = 1'b1;
    tick(2);
    check("rst_pend_no_commit", o_mode, 2);
    check("rst_pend_frame_1", o_frame_cnt, 1);
    frame_gap();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
